// File: rtl/dac_sample_feeder.sv
// FIFO-buffered code source for the R2R+PWM DAC driver, with start-up priming and underflow handling.
// Optional saturating underflow counter on port uflow_cnt when FEEDER_UFLOW_CNT_EN is defined.
module dac_sample_feeder #(
    parameter int R2R_BITS    = 4,
    parameter int PWM_BITS    = 12,
    parameter int AW          = 4,
    parameter int START_LEVEL = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [R2R_BITS+PWM_BITS-1:0] s_data,
    input  logic                         val_req,
    output logic [R2R_BITS+PWM_BITS-1:0] dac_val,
    output logic                         underflow,
    output logic [AW:0]                  level,
    output logic [1:0]                   state
`ifdef FEEDER_UFLOW_CNT_EN
    ,
    output logic [15:0]                  uflow_cnt
`endif
);

    localparam int W = R2R_BITS + PWM_BITS;
    localparam int D = 2 ** AW;
    localparam logic [AW:0] START_LVL = (AW+1)'(START_LEVEL);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        STARVED = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  mem [D];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          full, wr_en, pop, uflow_d;

    // level[AW] is only set when the FIFO holds exactly D entries.
    assign full    = level[AW];
    assign s_ready = !full;
    assign wr_en   = s_valid && s_ready && !flush;
    assign state   = state_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and infers a latch.
        state_d = state_q;
        pop     = 1'b0;
        uflow_d = 1'b0;
        if (val_req && !flush) begin
            unique case (state_q)
                IDLE: begin
                    if (level >= START_LVL) begin
                        pop     = 1'b1;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (level != '0) begin
                        pop = 1'b1;
                    end else begin
                        uflow_d = 1'b1;
                        state_d = STARVED;
                    end
                end
                STARVED: begin
                    if (level >= START_LVL) begin
                        pop     = 1'b1;
                        state_d = RUN;
                    end else begin
                        uflow_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            dac_val   <= '0;
            underflow <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
        end else if (flush) begin
            state_q   <= IDLE;
            dac_val   <= '0;
            underflow <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
        end else begin
            state_q   <= state_d;
            underflow <= uflow_d;
            if (pop) begin
                dac_val <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // NOTE: the storage array has no reset; occupancy and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= s_data;
        end
    end

`ifdef FEEDER_UFLOW_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uflow_cnt <= '0;
        end else if (flush) begin
            uflow_cnt <= '0;
        end else if (uflow_d && uflow_cnt != 16'hFFFF) begin
            uflow_cnt <= uflow_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Directed self-checking bench for dac_sample_feeder: priming, ordering, full, underflow, flush, async reset.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_dac_sample_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        val_req;
    logic [15:0] dac_val;
    logic        underflow;
    logic [4:0]  level;
    logic [1:0]  state;
`ifdef FEEDER_UFLOW_CNT_EN
    logic [15:0] uflow_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    dac_sample_feeder #(
        .R2R_BITS(4), .PWM_BITS(12), .AW(4), .START_LEVEL(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
        .val_req(val_req),
        .dac_val(dac_val),
        .underflow(underflow),
        .level(level),
`ifdef FEEDER_UFLOW_CNT_EN
        .uflow_cnt(uflow_cnt),
`endif
        .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock edge with the given inputs applied, then inputs return to idle.
    task automatic cyc(input logic v, input logic [15:0] d, input logic r, input logic f);
        @(negedge clk);
        s_valid = v;
        s_data  = d;
        val_req = r;
        flush   = f;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        val_req = 1'b0;
        flush   = 1'b0;
    endtask

    task automatic wr(input logic [15:0] d);
        cyc(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic req();
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; val_req = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_dac", dac_val, 0);
        check("rst_uflow", underflow, 0);
        check("rst_level", level, 0);
        check("rst_state", state, 0);
        check("rst_ready", s_ready, 1);
        rst = 1'b0;

        // Priming: three codes are not enough to start.
        wr(16'h1234); wr(16'h2345); wr(16'h3456);
        check("prime_level3", level, 3);
        req();
        check("prime_idle_dac", dac_val, 16'h0);
        check("prime_idle_state", state, 0);
        check("prime_idle_uflow", underflow, 0);
        wr(16'h4567);
        req();
        check("prime_run_dac", dac_val, 16'h1234);
        check("prime_run_state", state, 1);
        check("prime_run_level", level, 3);
        req(); check("drain_1", dac_val, 16'h2345);
        req(); check("drain_2", dac_val, 16'h3456);
        req(); check("drain_3", dac_val, 16'h4567);
        check("drain_level", level, 0);

        // Underflow: two starved requests.
        req();
        check("uf1_dac", dac_val, 16'h4567);
        check("uf1_pulse", underflow, 1);
        check("uf1_state", state, 2);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        check("uf1_pulse_end", underflow, 0);
        req();
        check("uf2_dac", dac_val, 16'h4567);
        check("uf2_pulse", underflow, 1);
        check("uf2_state", state, 2);
`ifdef FEEDER_UFLOW_CNT_EN
        check("uf_cnt", uflow_cnt, 2);
`endif
        for (int i = 1; i <= 4; i++) wr(16'hA000 + 16'(i));
        req();
        check("recover_dac", dac_val, 16'hA001);
        check("recover_state", state, 1);
        check("recover_uflow", underflow, 0);
        check("recover_level", level, 3);
        for (int i = 2; i <= 4; i++) begin
            req();
            check("recover_drain", dac_val, 16'hA000 + 16'(i));
        end

        // Order and full.
        for (int i = 1; i <= 16; i++) wr(16'(i));
        check("full_level", level, 16);
        check("full_ready", s_ready, 0);
        wr(16'h0011);
        check("full_reject_level", level, 16);
        for (int i = 1; i <= 16; i++) begin
            req();
            check("order", dac_val, 32'(i));
        end
        check("order_level", level, 0);
        check("order_state", state, 1);

        // Simultaneous write and pop at level 5.
        for (int i = 1; i <= 5; i++) wr(16'hB000 + 16'(i));
        cyc(1'b1, 16'hB006, 1'b1, 1'b0);
        check("simul_dac", dac_val, 16'hB001);
        check("simul_level", level, 5);
        for (int i = 2; i <= 6; i++) begin
            req();
            check("simul_order", dac_val, 16'hB000 + 16'(i));
        end

        // Flush with write and request in the same cycle.
        wr(16'hC001); wr(16'hC002); wr(16'hC003);
        req();
        check("preflush_dac", dac_val, 16'hC001);
        cyc(1'b1, 16'hC0FF, 1'b1, 1'b1);
        check("flush_level", level, 0);
        check("flush_dac", dac_val, 0);
        check("flush_state", state, 0);
        check("flush_uflow", underflow, 0);
        check("flush_ready", s_ready, 1);
`ifdef FEEDER_UFLOW_CNT_EN
        check("flush_cnt", uflow_cnt, 0);
`endif
        for (int i = 1; i <= 4; i++) wr(16'hD000 + 16'(i));
        req();
        check("postflush_dac", dac_val, 16'hD001);
        check("postflush_state", state, 1);

        // Asynchronous reset mid-RUN with level 7.
        for (int i = 5; i <= 8; i++) wr(16'hD000 + 16'(i));
        check("prerst_level", level, 7);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_dac", dac_val, 0);
        check("arst_uflow", underflow, 0);
        check("arst_level", level, 0);
        check("arst_state", state, 0);
        check("arst_ready", s_ready, 1);
`ifdef FEEDER_UFLOW_CNT_EN
        check("arst_cnt", uflow_cnt, 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
